eindopdracht_switch_irq_ctrl: RTL and testbench

//   Avalon-MM slave controller for the board slide switches: synchronises, debounces and

---
 rtl/eindopdracht_switch_irq_ctrl_if.sv | 28 ++
 rtl/eindopdracht_switch_irq_ctrl.sv | 140 ++++++++++++++
 tb/tb_eindopdracht_switch_irq_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/eindopdracht_switch_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch interrupt controller: register
// access signals plus the level interrupt back to the processor.
interface eindopdracht_switch_irq_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/eindopdracht_switch_irq_ctrl.sv
// Switch interrupt controller: synchronises, debounces and rising-edge detects the
// slide switches, exposing DATA/MASK/EDGE/PERIOD registers and a maskable level irq.
// Build option: define SW_IRQ_DEBOUNCE_EN to include the per-bit debounce counters and
// the PERIOD register; without it stable follows the synchroniser and PERIOD reads 0.
module eindopdracht_switch_irq_ctrl #(
  parameter int unsigned N_SW        = 10,
  parameter int unsigned DEB_W       = 16,
  parameter int unsigned DEB_DEFAULT = 50000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_SW-1:0]               in_port,
  eindopdracht_switch_irq_ctrl_if.slave bus
);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrMask   = 2'd1;
  localparam logic [1:0] AddrEdge   = 2'd2;
  localparam logic [1:0] AddrPeriod = 2'd3;

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [N_SW-1:0] stable_q, stable_d;
  logic [N_SW-1:0] mask_q, mask_d;
  logic [N_SW-1:0] edge_q, edge_d;
  logic [31:0]     readdata_q, readdata_d;
  logic            wr;
  logic [N_SW-1:0] w1c;

  assign wr  = bus.chipselect & ~bus.write_n;
  assign w1c = (wr && (bus.address == AddrEdge)) ? bus.writedata[N_SW-1:0] : '0;

  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

`ifdef SW_IRQ_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] CntOne = DEB_W'(1);

  logic [DEB_W-1:0] period_q, period_d;
  logic [DEB_W-1:0] cnt_q [N_SW];
  logic [DEB_W-1:0] cnt_d [N_SW];

  // Per-bit debounce: commit once the mismatch has persisted past the period.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(N_SW); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < period_q) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else begin
        // '>=' so a lowered period commits immediately instead of wrapping.
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end
    end
  end

  // Period register write.
  always_comb begin
    period_d = period_q;
    if (wr && (bus.address == AddrPeriod)) begin
      period_d = bus.writedata[DEB_W-1:0];
    end
  end

  // Debounce counter and period state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_q <= DEB_W'(DEB_DEFAULT);
      for (int i = 0; i < int'(N_SW); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      period_q <= period_d;
      for (int i = 0; i < int'(N_SW); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic [DEB_W-1:0] unused_period;
  assign unused_period = DEB_W'(DEB_DEFAULT);

  // No debounce: stable simply follows the synchroniser output.
  always_comb begin
    stable_d = sync2_q;
  end
`endif

  // Mask write and edge capture; a new rising edge beats a same-cycle W1C.
  always_comb begin
    mask_d = mask_q;
    if (wr && (bus.address == AddrMask)) begin
      mask_d = bus.writedata[N_SW-1:0];
    end
    edge_d = (edge_q & ~w1c) | (stable_d & ~stable_q);
  end

  // Read mux from current register state, so a same-cycle write reads the old value.
  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      AddrData: readdata_d[N_SW-1:0] = stable_q;
      AddrMask: readdata_d[N_SW-1:0] = mask_q;
      AddrEdge: readdata_d[N_SW-1:0] = edge_q;
      AddrPeriod: begin
`ifdef SW_IRQ_DEBOUNCE_EN
        readdata_d[DEB_W-1:0] = period_q;
`else
        readdata_d = '0;
`endif
      end
      default: readdata_d = '0;
    endcase
  end

  // Synchroniser, debounced state and register file.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_eindopdracht_switch_irq_ctrl.sv
// Directed bench for the switch interrupt controller; adapts latencies and the
// PERIOD checks to whether SW_IRQ_DEBOUNCE_EN is defined.
module tb_eindopdracht_switch_irq_ctrl;
  localparam int unsigned NSw = 10;

`ifdef SW_IRQ_DEBOUNCE_EN
  localparam int P = 4;
  localparam logic [31:0] PerReset = 32'd50000;
  localparam logic [31:0] PerWrite = 32'd4;
  localparam logic [31:0] PerRead  = 32'd4;
`else
  localparam int P = 0;
  localparam logic [31:0] PerReset = 32'd0;
  localparam logic [31:0] PerWrite = 32'd7;
  localparam logic [31:0] PerRead  = 32'd0;
`endif

  logic            clk;
  logic            reset_n;
  logic [NSw-1:0]  in_port;
  int              checks;
  int              errors;

  eindopdracht_switch_irq_ctrl_if bus ();

  eindopdracht_switch_irq_ctrl #(
    .N_SW        (NSw),
    .DEB_W       (16),
    .DEB_DEFAULT (50000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.write_n    = 1'b1;
    bus.chipselect = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    chk(tag, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    in_port        = '0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    reset_n = 1'b1;

    // Reset register values.
    rd(2'd0, 32'd0, "rst_data");
    rd(2'd1, 32'd0, "rst_mask");
    rd(2'd2, 32'd0, "rst_edge");
    rd(2'd3, PerReset, "rst_period");

    wr(2'd3, PerWrite);
    rd(2'd3, PerRead, "period_rw");
    wr(2'd1, 32'h001);
    rd(2'd1, 32'h001, "mask_rw");

    // Exact latency of a rising step on bit0 to irq and DATA.
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    in_port[0]     = 1'b1;
    repeat (2 + P) @(negedge clk);
    chk("irq_before_commit", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    chk("irq_at_commit", {31'd0, bus.irq}, 32'd1);
    chk("data_before_read", bus.readdata, 32'd0);
    @(negedge clk);
    chk("data_after_commit", bus.readdata, 32'h001);
    bus.chipselect = 1'b0;

    rd(2'd2, 32'h001, "edge_set");
    rd(2'd2, 32'h001, "edge_read_noclr");
    wr(2'd2, 32'h000);
    rd(2'd2, 32'h001, "edge_w0_noeffect");
    chk("irq_pending", {31'd0, bus.irq}, 32'd1);
    wr(2'd2, 32'h001);
    chk("irq_after_w1c", {31'd0, bus.irq}, 32'd0);
    rd(2'd2, 32'h000, "edge_cleared");

    // Falling edge does not capture.
    in_port[0] = 1'b0;
    repeat (P + 6) @(negedge clk);
    rd(2'd0, 32'h000, "data_fall");
    rd(2'd2, 32'h000, "edge_fall_none");

`ifdef SW_IRQ_DEBOUNCE_EN
    // Three-cycle glitch is shorter than P+1 and must be rejected.
    in_port[3] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[3] = 1'b0;
    repeat (10) @(negedge clk);
    rd(2'd0, 32'h000, "glitch_data");
    rd(2'd2, 32'h000, "glitch_edge");
    chk("glitch_irq", {31'd0, bus.irq}, 32'd0);
`else
    // Without debounce a one-cycle pulse propagates and captures an edge.
    in_port[3] = 1'b1;
    @(negedge clk);
    in_port[3] = 1'b0;
    repeat (5) @(negedge clk);
    rd(2'd0, 32'h000, "pulse_data");
    rd(2'd2, 32'h008, "pulse_edge");
    chk("pulse_irq_masked", {31'd0, bus.irq}, 32'd0);
    wr(2'd2, 32'h008);
`endif

    // Setting a MASK bit over a pending edge raises irq; clearing it drops irq.
    in_port[3] = 1'b1;
    repeat (P + 6) @(negedge clk);
    rd(2'd2, 32'h008, "edge_bit3");
    chk("irq_unmasked", {31'd0, bus.irq}, 32'd0);
    wr(2'd1, 32'h009);
    chk("irq_mask_set", {31'd0, bus.irq}, 32'd1);
    wr(2'd1, 32'h001);
    chk("irq_mask_clr", {31'd0, bus.irq}, 32'd0);
    in_port[3] = 1'b0;
    repeat (P + 6) @(negedge clk);
    wr(2'd2, 32'h008);
    rd(2'd2, 32'h000, "edge_bit3_clr");

    // New rising edge on bit2 on the same edge as its W1C: set wins.
    in_port[2] = 1'b1;
    repeat (P + 6) @(negedge clk);
    rd(2'd2, 32'h004, "edge_bit2");
    in_port[2] = 1'b0;
    repeat (P + 6) @(negedge clk);
    in_port[2] = 1'b1;
    repeat (2 + P) @(negedge clk);
    wr(2'd2, 32'h004);
    rd(2'd2, 32'h004, "set_wins");
    wr(2'd2, 32'h004);
    rd(2'd2, 32'h000, "edge_bit2_clr");
    in_port[2] = 1'b0;
    repeat (P + 6) @(negedge clk);

`ifdef SW_IRQ_DEBOUNCE_EN
    // Lowering PERIOD mid-count commits on the following edge.
    wr(2'd3, 32'd1000);
    wr(2'd1, 32'h021);
    in_port[5] = 1'b1;
    repeat (500) @(negedge clk);
    rd(2'd0, 32'h000, "long_count_data");
    chk("long_count_irq", {31'd0, bus.irq}, 32'd0);
    wr(2'd3, 32'd10);
    chk("irq_at_period_write", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    chk("irq_after_period_write", {31'd0, bus.irq}, 32'd1);
    rd(2'd0, 32'h020, "data_bit5");
`else
    // All switches at once, latency E0+3; PERIOD stays 0 after a write.
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    in_port        = 10'h3FF;
    repeat (3) @(negedge clk);
    chk("all_data_early", bus.readdata, 32'h000);
    chk("all_irq", {31'd0, bus.irq}, 32'd1);
    @(negedge clk);
    chk("all_data", bus.readdata, 32'h3FF);
    bus.chipselect = 1'b0;
    rd(2'd2, 32'h3FF, "all_edge");
    wr(2'd3, 32'd7);
    rd(2'd3, 32'd0, "period_ignored");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
